// File: rtl/fir_controller.sv
`default_nettype none
// ============================================================================
// fir_controller : FIR sequencer. It accepts a sample, issues the taps, aligns
// the MAC enables to the multiplier latency and hands off the finished result.
// Optional macro FIR_CTRL_BACK2BACK_EN. Revision: 1.0
// ============================================================================
module fir_controller #(
  parameter int unsigned TAP_NUM      = 64,
  parameter int unsigned MULT_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       shift_en,
  output logic                       acc_clear,
  output logic [$clog2(TAP_NUM)-1:0] tap_idx,
  output logic                       tap_valid,
  output logic                       mac_en,
  output logic                       busy
);

  localparam int unsigned TAP_W = $clog2(TAP_NUM);
  localparam int unsigned CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
  localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(TAP_NUM - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(MULT_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_idx_q, tap_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  // in_ready is masked while reset is held so nothing is accepted during reset.
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      if (state_q == IDLE) begin
        in_ready = 1'b1;
      end
`ifdef FIR_CTRL_BACK2BACK_EN
      else if (state_q == OUT) begin
        in_ready = out_ready;
      end
`else
      else begin
        in_ready = 1'b0;
      end
`endif
    end
  end

  assign accept    = in_valid & in_ready;
  assign shift_en  = accept;
  assign acc_clear = accept;
  assign tap_valid = (state_q == ISSUE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign tap_idx   = tap_idx_q;

  always_comb begin
    state_d   = state_q;
    tap_idx_d = tap_idx_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ISSUE;
          tap_idx_d = '0;
        end
      end
      ISSUE: begin
        if (tap_idx_q == TAP_LAST) begin
          tap_idx_d = '0;
          if (MULT_LATENCY == 0) begin
            state_d = OUT;
          end else begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end
        end else begin
          tap_idx_d = tap_idx_q + TAP_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OUT: begin
        // accept can only be high here when back-to-back handoff is built in.
        if (out_ready) begin
          if (accept) begin
            state_d   = ISSUE;
            tap_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      tap_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tap_idx_q <= tap_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  generate
    if (MULT_LATENCY == 0) begin : g_mac_direct
      assign mac_en = tap_valid;
    end else begin : g_mac_delay
      logic [MULT_LATENCY-1:0] mac_pipe_q;
      always_ff @(posedge clk) begin
        if (!reset) begin
          mac_pipe_q <= '0;
        end else begin
          mac_pipe_q <= (mac_pipe_q << 1) | MULT_LATENCY'(tap_valid);
        end
      end
      assign mac_en = mac_pipe_q[MULT_LATENCY-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fir_controller.sv
`default_nettype none
// ============================================================================
// tb_fir_controller : scoreboard bench for fir_controller (default and
// TAP_NUM=4/MULT_LATENCY=0 instances). Revision: 1.0
// ============================================================================
module tb_fir_controller;

`ifdef FIR_CTRL_BACK2BACK_EN
  localparam int PER = 67;
`else
  localparam int PER = 68;
`endif

  logic       clk;
  logic       rst;
  logic       a_in_valid, a_in_ready, a_out_ready, a_out_valid;
  logic       a_shift_en, a_acc_clear, a_tap_valid, a_mac_en, a_busy;
  logic [5:0] a_tap_idx;
  logic       b_in_valid, b_in_ready, b_out_ready, b_out_valid;
  logic       b_shift_en, b_acc_clear, b_tap_valid, b_mac_en, b_busy;
  logic [1:0] b_tap_idx;

  fir_controller u_dut_a (
    .clk(clk), .reset(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_ready(a_out_ready), .out_valid(a_out_valid), .shift_en(a_shift_en),
    .acc_clear(a_acc_clear), .tap_idx(a_tap_idx), .tap_valid(a_tap_valid),
    .mac_en(a_mac_en), .busy(a_busy)
  );

  fir_controller #(.TAP_NUM(4), .MULT_LATENCY(0)) u_dut_b (
    .clk(clk), .reset(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_ready(b_out_ready), .out_valid(b_out_valid), .shift_en(b_shift_en),
    .acc_clear(b_acc_clear), .tap_idx(b_tap_idx), .tap_valid(b_tap_valid),
    .mac_en(b_mac_en), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {int lat; int macs; int mac0;} exp_t;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int   out_a[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: measures accept-to-output latency and MAC pulses per sample.
  int a_acc, a_macs, a_mac0;
  bit a_seen;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      a_macs = 0;
      a_seen = 0;
    end else begin
      if (a_out_valid && !a_seen) begin
        a_seen = 1;
        out_a.push_back(cyc);
        if (sb_a.size() == 0) check("A_unexpected_out", 1, 0);
        else begin
          e = sb_a[0];
          check("A_latency", cyc - a_acc, e.lat);
        end
      end
      if (a_out_valid && a_out_ready && sb_a.size() != 0) begin
        e = sb_a.pop_front();
        check("A_mac_count", a_macs, e.macs);
        check("A_first_mac", a_mac0 - a_acc, e.mac0);
      end
      if (a_out_valid && a_out_ready) a_seen = 0;
      if (a_shift_en) begin
        a_acc  = cyc;
        a_macs = 0;
      end
      if (a_mac_en) begin
        if (a_macs == 0) a_mac0 = cyc;
        a_macs++;
      end
    end
  end

  // Monitor B: same measurements for the 4-tap, zero-latency instance.
  int b_acc, b_macs, b_mac0;
  bit b_seen;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      b_macs = 0;
      b_seen = 0;
    end else begin
      if (b_out_valid && !b_seen) begin
        b_seen = 1;
        if (sb_b.size() == 0) check("B_unexpected_out", 1, 0);
        else begin
          e = sb_b[0];
          check("B_latency", cyc - b_acc, e.lat);
        end
      end
      if (b_out_valid && b_out_ready && sb_b.size() != 0) begin
        e = sb_b.pop_front();
        check("B_mac_count", b_macs, e.macs);
        check("B_first_mac", b_mac0 - b_acc, e.mac0);
      end
      if (b_out_valid && b_out_ready) b_seen = 0;
      if (b_shift_en) begin
        b_acc  = cyc;
        b_macs = 0;
      end
      if (b_mac_en) begin
        if (b_macs == 0) b_mac0 = cyc;
        b_macs++;
      end
    end
  end

  task automatic wait_idle_a();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      nxt();
      @(negedge clk);
      if (!a_busy) done = 1;
    end
    check("A_idle_reached", int'(done), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int sh[3];
    int n, wo, wm;
    bit got;
    rst = 0;
    a_in_valid = 1; a_out_ready = 1;
    b_in_valid = 0; b_out_ready = 1;

    // Reset held with in_valid high
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", int'(a_in_ready), 0);
    check("rst_shift_en", int'(a_shift_en), 0);
    check("rst_acc_clear", int'(a_acc_clear), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_out_valid", int'(a_out_valid), 0);
    check("rst_tap_valid", int'(a_tap_valid), 0);
    check("rst_mac_en", int'(a_mac_en), 0);
    check("rst_tap_idx", int'(a_tap_idx), 0);
    nxt(); rst = 1; a_in_valid = 0;
    @(negedge clk);
    check("rel_in_ready", int'(a_in_ready), 1);

    // Full sample, ignored in_valid pulses during ISSUE/DRAIN
    nxt(); a_in_valid = 1;
    @(negedge clk);
    check("t2_shift_en", int'(a_shift_en), 1);
    check("t2_acc_clear", int'(a_acc_clear), 1);
    sb_a.push_back('{67, 64, 3});
    for (int k = 0; k < 64; k++) begin
      nxt(); a_in_valid = (k % 3 == 0);
      @(negedge clk);
      check("t2_tap_idx", int'(a_tap_idx), k);
      check("t2_tap_valid", int'(a_tap_valid), 1);
      check("t2_shift_ignored", int'(a_shift_en), 0);
      check("t2_in_ready", int'(a_in_ready), 0);
    end
    nxt(); a_in_valid = 1;
    @(negedge clk);
    check("drain_tap_valid", int'(a_tap_valid), 0);
    check("drain_tap_idx", int'(a_tap_idx), 0);
    check("drain_shift", int'(a_shift_en), 0);
    check("drain_busy", int'(a_busy), 1);
    nxt(); a_in_valid = 0;
    wait_idle_a();

    // Output stall for 5 cycles
    nxt(); a_in_valid = 1; a_out_ready = 0;
    @(negedge clk);
    sb_a.push_back('{67, 64, 3});
    nxt(); a_in_valid = 0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (a_out_valid) got = 1;
      else nxt();
    end
    check("stall_out_seen", int'(got), 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", int'(a_out_valid), 1);
      check("stall_in_ready", int'(a_in_ready), 0);
      check("stall_shift", int'(a_shift_en), 0);
      nxt(); a_in_valid = (i < 4);
      @(negedge clk);
    end
    nxt(); a_in_valid = 0; a_out_ready = 1;
    wait_idle_a();

    // TAP_NUM=4, MULT_LATENCY=0
    nxt(); b_in_valid = 1;
    @(negedge clk);
    check("b_shift_en", int'(b_shift_en), 1);
    sb_b.push_back('{5, 4, 1});
    for (int k = 0; k < 4; k++) begin
      nxt(); b_in_valid = 0;
      @(negedge clk);
      check("b_tap_idx", int'(b_tap_idx), k);
      check("b_tap_valid", int'(b_tap_valid), 1);
      check("b_mac_en", int'(b_mac_en), 1);
      check("b_out_early", int'(b_out_valid), 0);
    end
    nxt();
    @(negedge clk);
    check("b_out_valid", int'(b_out_valid), 1);
    check("b_mac_after", int'(b_mac_en), 0);
    nxt();
    @(negedge clk);
    check("b_idle", int'(b_busy), 0);

    // Reset while tap_idx=20
    nxt(); a_in_valid = 1;
    @(negedge clk);
    for (int k = 0; k <= 20; k++) begin
      nxt(); a_in_valid = 0;
      if (k == 20) rst = 0;
    end
    @(negedge clk);
    check("abort_tap_idx_before", int'(a_tap_idx), 20);
    nxt();
    @(negedge clk);
    check("abort_tap_idx", int'(a_tap_idx), 0);
    check("abort_busy", int'(a_busy), 0);
    check("abort_mac_en", int'(a_mac_en), 0);
    check("abort_in_ready", int'(a_in_ready), 0);
    nxt(); rst = 1;
    @(negedge clk);
    check("abort_rel_ready", int'(a_in_ready), 1);
    wo = 0; wm = 0;
    for (int i = 0; i < 80; i++) begin
      nxt();
      @(negedge clk);
      if (a_out_valid) wo++;
      if (a_mac_en) wm++;
    end
    check("abort_no_out", wo, 0);
    check("abort_no_mac", wm, 0);
    nxt(); a_in_valid = 1;
    @(negedge clk);
    sb_a.push_back('{67, 64, 3});
    nxt(); a_in_valid = 0;
    wait_idle_a();

    // Continuous in_valid and out_ready: sample period
    nxt(); a_in_valid = 1; a_out_ready = 1;
    for (int s = 0; s < 3; s++) begin
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (a_shift_en) begin
          got = 1;
          sh[s] = cyc;
          sb_a.push_back('{67, 64, 3});
        end
        nxt();
      end
      check("period_accept_seen", int'(got), 1);
    end
    a_in_valid = 0;
    wait_idle_a();
    check("shift_period_1", sh[1] - sh[0], PER);
    check("shift_period_2", sh[2] - sh[1], PER);
    n = out_a.size();
    check("out_count", n, 6);
    if (n >= 3) begin
      check("out_period_1", out_a[n-2] - out_a[n-3], PER);
      check("out_period_2", out_a[n-1] - out_a[n-2], PER);
    end
    check("sb_a_empty", sb_a.size(), 0);
    check("sb_b_empty", sb_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_controller.md
# fir_controller

Sequencing controller for the FIR filter datapath. Accepts one input sample per valid/ready handshake and loads it into the delay line. Steps a tap index across all coefficients to drive the configurable pipelined multiplier. Aligns accumulator enables to the multiplier latency, then presents the finished output under a valid/ready handshake.

## Interface
Parameters:
- TAP_NUM, 64, number of filter taps; at least 2.
- MULT_LATENCY, 2, pipeline stages of the multiplier between tap issue and product valid; at least 0.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  input sample available.
- in_ready  output  1  controller can accept a sample.
- out_ready  input  1  downstream consumes the output.
- out_valid  output  1  accumulator holds a finished output.
- shift_en  output  1  load the new sample into the delay line this cycle.
- acc_clear  output  1  zero the accumulator this cycle.
- tap_idx  output  $clog2(TAP_NUM)  coefficient / delay-line select for the multiplier.
- tap_valid  output  1  tap_idx is a live issue to the multiplier.
- mac_en  output  1  add the multiplier product to the accumulator.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: sample accepted, with shift_en=1 and acc_clear=1 (combinational, accept cycle only).
  - Next state ISSUE with tap_idx=0.
- ISSUE:
  - tap_valid=1; tap_idx increments by 1 each cycle, from 0 to TAP_NUM-1.
  - At tap_idx=TAP_NUM-1, next state is DRAIN. If MULT_LATENCY=0, next state is OUT.
  - tap_idx never wraps inside ISSUE. It returns to 0 on leaving ISSUE.
- DRAIN: lasts exactly MULT_LATENCY cycles, counted by an internal down-counter. Then OUT.
- mac_en: tap_valid delayed through a MULT_LATENCY-deep register chain; equal to tap_valid when MULT_LATENCY=0. Exactly TAP_NUM mac_en pulses occur per sample.
- OUT:
  - out_valid=1, held stable until out_ready.
  - On out_ready: next state IDLE.
- in_ready=0 in ISSUE and DRAIN; it is 0 in OUT unless the back-to-back feature is compiled in. in_valid while in_ready=0 is ignored and not stored.
- shift_en and acc_clear never assert outside an accept cycle.

## Timing
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - tap_idx=0; tap_valid=0, mac_en=0, out_valid=0, busy=0, shift_en=0, acc_clear=0.
  - The mac_en delay chain and the DRAIN counter are cleared.
  - in_ready=0 while reset is held low, 1 in the first cycle after release.
- Reset mid-operation aborts the current sample: no further mac_en, and no out_valid for it.
- Sample accepted at cycle T:
  - tap_idx=k with tap_valid at T+1+k.
  - mac_en for tap k at T+1+k+MULT_LATENCY.
  - out_valid first high at T+TAP_NUM+MULT_LATENCY+1.
  - Defaults give out_valid at T+67.
- Minimum sample period without back-to-back: TAP_NUM+MULT_LATENCY+2 cycles.
- The back-to-back path (see Configuration) cannot overlap samples, because the accumulator is cleared only after the result has been consumed.

## Configuration
- FIR_CTRL_BACK2BACK_EN defined:
  - In OUT, in_ready=out_ready.
  - If out_ready and in_valid occur in the same cycle, the output completes, the new sample is accepted (shift_en=1, acc_clear=1), and the next state is ISSUE directly.
  - Sample period drops to TAP_NUM+MULT_LATENCY+1.
- Undefined: in_ready=0 in OUT; OUT always returns to IDLE first.

## Test plan
- Reset with in_valid=1, then release: in_ready=1 in the first cycle after release. While reset is held, no shift_en and all outputs are at reset values.
- Defaults, accept at cycle 10, out_ready=1: tap_idx runs 0..63 over cycles 11..74; mac_en is high in cycles 13..76 (64 pulses); out_valid is high at cycle 77 for one cycle.
- out_ready held low for 5 cycles in OUT: out_valid stays high and in_ready stays 0 throughout. in_valid pulses during ISSUE and DRAIN are ignored, and shift_en stays 0.
- MULT_LATENCY=0, TAP_NUM=4: mac_en coincides with tap_valid for exactly 4 cycles, and out_valid rises 5 cycles after accept, with no DRAIN state.
- reset=0 while tap_idx=20: the next cycle shows IDLE, tap_idx=0, no mac_en, and out_valid never asserts. A new sample then completes normally with 64 mac_en pulses.
- With FIR_CTRL_BACK2BACK_EN, in_valid and out_ready both held at 1: shift_en recurs every 67 cycles (defaults) and out_valid pulses every 67 cycles. Without the macro, both recur every 68 cycles.
